// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-read-port integer register file with an
// integrated per-register scoreboard (pending-write busy bits).
//
// Decode issues destination registers, which sets their busy bits. Writeback
// retires them, which stores the data and clears the busy bit. A flush clears
// every busy bit. Register x0 always reads zero and is never busy.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a same-cycle writeback is forwarded to matching read ports.
//   undefined : reads return the stored value and busy bit; a written value
//               becomes visible on the following cycle.
//
// The read path is combinational, so read data follows the register contents
// with zero latency. o_busy_cnt is registered and lags the busy bits by one
// cycle.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rs_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rs_data,
  output logic [NUM_RD-1:0]          o_rs_busy,
  input  logic                       i_rd_wren,
  input  logic [ADDR_W-1:0]          i_rd_addr,
  input  logic [DATA_W-1:0]          i_rd_data,
  input  logic                       i_iss_valid,
  input  logic [ADDR_W-1:0]          i_iss_addr,
  input  logic                       i_flush,
  output logic [ADDR_W:0]            o_busy_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // One-hot decode of a register address into a busy-bit mask.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

  // Number of set bits in the busy vector.
  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] c;
    c = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [ADDR_W:0]     busy_cnt_r;
  logic                wr_en_s;
  logic                iss_en_s;

  // Writes and issues that target x0 are dropped here, so x0 never changes.
  assign wr_en_s  = i_rd_wren   && (i_rd_addr  != {ADDR_W{1'b0}});
  assign iss_en_s = i_iss_valid && (i_iss_addr != {ADDR_W{1'b0}});

  // Register storage: async clear, single writeback port (x0 is never written).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[i_rd_addr] <= i_rd_data;
    end
  end

  // Busy-bit next state: flush beats issue, and issue beats the retiring clear.
  always_comb begin
    clr_mask_s = wr_en_s  ? onehot(i_rd_addr)  : {NUM_REGS{1'b0}};
    set_mask_s = iss_en_s ? onehot(i_iss_addr) : {NUM_REGS{1'b0}};
    if (i_flush) begin
      busy_nxt_s = {NUM_REGS{1'b0}};
    end else begin
      busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end
  end

  // Busy-bit register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Busy counter: popcount of the current busy bits, one cycle behind them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_cnt_r <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_cnt_r <= popcount(busy_r);
    end
  end

  assign o_busy_cnt = busy_cnt_r;

`ifdef REGFILE_BYPASS_EN
  logic byp_busy_s;
  // A forwarded register stays busy only if a new producer issues to it now.
  assign byp_busy_s = iss_en_s && !i_flush && (i_iss_addr == i_rd_addr);
`endif

  // Independent read ports.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              busy_s;

    assign addr_s = i_rs_addr[k*ADDR_W +: ADDR_W];

    // Read mux (with optional writeback forwarding).
    always_comb begin
      data_s = regs_r[addr_s];
      busy_s = busy_r[addr_s];
`ifdef REGFILE_BYPASS_EN
      if (wr_en_s && (i_rd_addr == addr_s)) begin
        data_s = i_rd_data;
        busy_s = byp_busy_s;
      end else begin
        data_s = regs_r[addr_s];
        busy_s = busy_r[addr_s];
      end
`endif
    end

    assign o_rs_data[k*DATA_W +: DATA_W] = data_s;
    assign o_rs_busy[k]                  = busy_s;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb (3 read ports).
// Directed scenarios followed by randomized traffic. Expected values come from
// a reference model made of plain arrays that applies the register-file and
// scoreboard rules once per clock.
module tb_regfile_sb;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 3;

  logic              i_clk;
  logic              i_rst_n;
  logic [NRD*AW-1:0] i_rs_addr;
  logic [NRD*DW-1:0] o_rs_data;
  logic [NRD-1:0]    o_rs_busy;
  logic              i_rd_wren;
  logic [AW-1:0]     i_rd_addr;
  logic [DW-1:0]     i_rd_data;
  logic              i_iss_valid;
  logic [AW-1:0]     i_iss_addr;
  logic              i_flush;
  logic [AW:0]       o_busy_cnt;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rs_addr  (i_rs_addr),
    .o_rs_data  (o_rs_data),
    .o_rs_busy  (o_rs_busy),
    .i_rd_wren  (i_rd_wren),
    .i_rd_addr  (i_rd_addr),
    .i_rd_data  (i_rd_data),
    .i_iss_valid(i_iss_valid),
    .i_iss_addr (i_iss_addr),
    .i_flush    (i_flush),
    .o_busy_cnt (o_busy_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model state.
  logic [DW-1:0] m_regs [32];
  bit            m_busy [32];
  int            m_cnt;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic drive(input bit wr, input int wa, input logic [DW-1:0] wd,
                       input bit iss, input int ia, input bit fl);
    i_rd_wren   = wr;
    i_rd_addr   = AW'(wa);
    i_rd_data   = wd;
    i_iss_valid = iss;
    i_iss_addr  = AW'(ia);
    i_flush     = fl;
  endtask

  task automatic rs_all(input int a);
    for (int k = 0; k < NRD; k++) i_rs_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("%s_data%0d", tag, k), 64'(o_rs_data[k*DW +: DW]), 64'd0);
      chk($sformatf("%s_busy%0d", tag, k), 64'(o_rs_busy[k]), 64'd0);
    end
    chk($sformatf("%s_cnt", tag), 64'(o_busy_cnt), 64'd0);
  endtask

  // Check reads and count for the current inputs, then clock once and update the model.
  task automatic tick();
    int a;
    int c;
    logic [DW-1:0] ed;
    bit eb;
    #1;
    for (int k = 0; k < NRD; k++) begin
      a  = int'(i_rs_addr[k*AW +: AW]);
      ed = (a == 0) ? '0 : m_regs[a];
      eb = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (i_rd_wren && i_rd_addr != 0 && int'(i_rd_addr) == a) begin
        ed = i_rd_data;
        eb = i_iss_valid && (i_iss_addr == i_rd_addr) && !i_flush;
      end
`endif
      chk($sformatf("rd_data%0d_x%0d", k, a), 64'(o_rs_data[k*DW +: DW]), 64'(ed));
      chk($sformatf("rd_busy%0d_x%0d", k, a), 64'(o_rs_busy[k]), 64'(eb));
    end
    chk("busy_cnt", 64'(o_busy_cnt), 64'(m_cnt));
    @(posedge i_clk);
    c = 0;
    for (int i = 1; i < 32; i++) c += int'(m_busy[i]);
    m_cnt = c;
    if (i_rd_wren && i_rd_addr != 0) m_regs[i_rd_addr] = i_rd_data;
    if (i_flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (i_rd_wren && i_rd_addr != 0) m_busy[i_rd_addr] = 1'b0;
      if (i_iss_valid && i_iss_addr != 0) m_busy[i_iss_addr] = 1'b1;
    end
    @(negedge i_clk);
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_rs_addr = '0;
    drive(0, 0, '0, 0, 0, 0);
    model_reset();
    #1 chk_zero("por");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Write/read, and x0 stays zero.
    rs_all(5); drive(1, 5, 32'hDEADBEEF, 0, 0, 0); tick();
    drive(0, 0, '0, 0, 0, 0); tick();
    rs_all(0); drive(1, 0, 32'h00001234, 0, 0, 0); tick();
    drive(0, 0, '0, 0, 0, 0); tick();

    // Scoreboard issue then retire.
    rs_all(7); drive(0, 0, '0, 1, 7, 0); tick();
    drive(0, 0, '0, 0, 0, 0); tick();
    tick();
    drive(1, 7, 32'h00000055, 0, 0, 0); tick();
    drive(0, 0, '0, 0, 0, 0); tick();
    tick();

    // Collision issue/writeback, then with flush.
    rs_all(9); drive(1, 9, 32'hAAAA0009, 1, 9, 0); tick();
    drive(0, 0, '0, 0, 0, 0); tick();
    drive(1, 9, 32'h11110009, 1, 9, 1); tick();
    drive(0, 0, '0, 0, 0, 0); tick();
    tick();

    // Writeback while reading the same register.
    rs_all(3); drive(1, 3, 32'hA5A5A5A5, 0, 0, 0); tick();
    drive(0, 0, '0, 0, 0, 0); tick();

    // Fill every busy bit, then flush.
    for (int a = 1; a < 32; a++) begin
      rs_all(a); drive(0, 0, '0, 1, a, 0); tick();
    end
    drive(0, 0, '0, 0, 0, 0); tick();
    #1 chk("fill_cnt", 64'(o_busy_cnt), 64'd31);
    drive(0, 0, '0, 0, 0, 1); tick();
    drive(0, 0, '0, 0, 0, 0); tick();
    #1 chk("flush_cnt", 64'(o_busy_cnt), 64'd0);

    // Randomized traffic on a narrow address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      int wa;
      wa = int'($urandom_range(0, 7));
      drive(($urandom_range(0, 1) == 1), wa, DW'($urandom),
            ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)),
            ($urandom_range(0, 15) == 0));
      for (int k = 0; k < NRD; k++) begin
        i_rs_addr[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? AW'(wa)
                                                           : AW'($urandom_range(0, 31));
      end
      tick();
    end

    // Reset mid-operation with a write and issue in flight.
    rs_all(12); drive(1, 12, 32'hCAFEF00D, 1, 12, 0);
    #2 i_rst_n = 1'b0;
    #1 chk_zero("midrst");
    model_reset();
    @(negedge i_clk);
    drive(0, 0, '0, 0, 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
